// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receiver.
// Holds the deframer state encoding and the fixed frame layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // A frame is accepted when data plus parity carry an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a level filter for one raw PS/2 pin.
// The output only follows the pin after FILTER equal consecutive samples.
module ps2_filter #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(FILTER + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: filters the pins, deframes device->host frames and
// queues good scancodes in a small FIFO that drives the CPU interrupt line.
module ps2_kbd
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       clr_ovf,
  output logic [7:0] q,
  output logic       empty,
  output logic       intr,
  output logic       ovf,
  output logic       perr
);

  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  logic clk_f;
  logic dat_f;
  logic clk_prev;
  logic fall;

  ps2_filter #(.FILTER(FILTER)) u_clk_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (ps2_clk),
    .level   (clk_f)
  );

  ps2_filter #(.FILTER(FILTER)) u_dat_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (ps2_dat),
    .level   (dat_f)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) clk_prev <= 1'b1;
    else          clk_prev <= clk_f;
  end

  assign fall = clk_prev & ~clk_f;

  // Deframer
  ps2_state_t    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    sr, sr_n;
  logic          par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          push_req, push_req_n;
  logic          perr_n;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sr       <= '0;
      par      <= 1'b0;
      to_cnt   <= '0;
      push_req <= 1'b0;
      perr     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      sr       <= sr_n;
      par      <= par_n;
      to_cnt   <= to_cnt_n;
      push_req <= push_req_n;
      perr     <= perr_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    sr_n       = sr;
    par_n      = par;
    to_cnt_n   = '0;
    push_req_n = 1'b0;
    perr_n     = 1'b0;

    // A stalled frame is abandoned silently once the bus has been quiet too long.
    if (state != IDLE && !fall) begin
      if (to_cnt == TW'(TIMEOUT - 1)) state_n = IDLE;
      else                             to_cnt_n = to_cnt + 1'b1;
    end

    if (fall) begin
      case (state)
        IDLE: begin
          if (dat_f == START_BIT) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          sr_n      = {dat_f, sr[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_f;
          state_n = STOP;
        end
        STOP: begin
          if (parity_ok(sr, par) && dat_f == STOP_BIT) push_req_n = 1'b1;
          else                                         perr_n     = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FIFO; sr holds the accepted byte during the push cycle
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_pop  = rd & ~empty;
  assign do_push = push_req & (~full | do_pop);
  assign drop    = push_req & full & ~do_pop;
  assign q       = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

  // NOTE: the storage array is not reset; the pointers alone define which
  // entries are valid, and q is forced to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= sr;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      intr   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      intr <= ~empty;
    end
  end

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed self-checking bench for ps2_kbd: drives PS/2 frames on the pins
// and checks the queued bytes, flags and interrupt against hand-computed values.
module tb_ps2_kbd;

  localparam int TIMEOUT_TB = 1000;
  localparam int HALF       = 20;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       rd;
  logic       clr_ovf;
  logic [7:0] q;
  logic       empty;
  logic       intr;
  logic       ovf;
  logic       perr;

  int n_assert = 0;
  int n_fail   = 0;
  int perr_cnt = 0;
  int perr_base;
  bit seen;

  ps2_kbd #(
    .FIFO_AW (4),
    .FILTER  (8),
    .TIMEOUT (TIMEOUT_TB)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rd      (rd),
    .clr_ovf (clr_ovf),
    .q       (q),
    .empty   (empty),
    .intr    (intr),
    .ovf     (ovf),
    .perr    (perr)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (perr === 1'b1) perr_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sends the first nbits of a frame; flip inverts the parity bit.
  task automatic send_frame(input logic [7:0] d, input logic flip, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    idle(2 * HALF);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clock);
    check(tag, {8'h00, q}, {8'h00, exp});
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rd      = 1'b0;
    clr_ovf = 1'b0;
    idle(3);
    check("rst_q", {8'h00, q}, 16'h0000);
    check("rst_empty", {15'd0, empty}, 16'd1);
    check("rst_intr", {15'd0, intr}, 16'd0);
    check("rst_ovf", {15'd0, ovf}, 16'd0);
    check("rst_perr", {15'd0, perr}, 16'd0);
    reset_n = 1'b1;
    idle(5);

    // 1: good frame then pop
    send_frame(8'h1C, 1'b0, 11);
    check("t1_q", {8'h00, q}, 16'h001C);
    check("t1_empty", {15'd0, empty}, 16'd0);
    check("t1_intr", {15'd0, intr}, 16'd1);
    pop_check("t1_pop", 8'h1C);
    idle(2);
    check("t1_empty_after", {15'd0, empty}, 16'd1);
    check("t1_intr_after", {15'd0, intr}, 16'd0);

    // 2: parity error then good F0
    perr_base = perr_cnt;
    send_frame(8'h1C, 1'b1, 11);
    check("t2_perr_pulses", 16'(perr_cnt - perr_base), 16'd1);
    check("t2_empty", {15'd0, empty}, 16'd1);
    send_frame(8'hF0, 1'b0, 11);
    check("t2_q", {8'h00, q}, 16'h00F0);
    pop_check("t2_pop", 8'hF0);

    // 3: partial frame, timeout, then good 32
    perr_base = perr_cnt;
    send_frame(8'h1C, 1'b0, 5);
    idle(TIMEOUT_TB + 10);
    send_frame(8'h32, 1'b0, 11);
    check("t3_q", {8'h00, q}, 16'h0032);
    check("t3_no_perr", 16'(perr_cnt - perr_base), 16'd0);
    pop_check("t3_pop", 8'h32);
    idle(1);
    check("t3_empty", {15'd0, empty}, 16'd1);

    // 4: overflow with 17 bytes
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 11);
    check("t4_ovf", {15'd0, ovf}, 16'd1);
    for (int i = 0; i < 16; i++) pop_check("t4_pop", 8'(i));
    idle(1);
    check("t4_empty", {15'd0, empty}, 16'd1);
    check("t4_ovf_sticky", {15'd0, ovf}, 16'd1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    idle(1);
    check("t4_ovf_clr", {15'd0, ovf}, 16'd0);

    // 5: push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) send_frame(8'hA0 + 8'(i), 1'b0, 11);
    check("t5_full_ovf", {15'd0, ovf}, 16'd0);
    send_frame(8'hB0, 1'b0, 10);
    ps2_dat = 1'b1;
    idle(HALF);
    ps2_clk = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * HALF && !seen; i++) begin
      @(negedge clock);
      if (dut.push_req === 1'b1) seen = 1'b1;
    end
    check("t5_push_seen", {15'd0, seen}, 16'd1);
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
    idle(2 * HALF);
    check("t5_ovf", {15'd0, ovf}, 16'd0);
    for (int i = 1; i < 16; i++) pop_check("t5_pop", 8'hA0 + 8'(i));
    check("t5_not_empty", {15'd0, empty}, 16'd0);
    pop_check("t5_last", 8'hB0);
    idle(1);
    check("t5_empty", {15'd0, empty}, 16'd1);

    // 6a: clock glitch shorter than the filter, data held low
    ps2_dat = 1'b0;
    idle(3 * HALF);
    ps2_clk = 1'b0;
    idle(6);
    ps2_clk = 1'b1;
    idle(3 * HALF);
    ps2_dat = 1'b1;
    idle(2 * HALF);
    send_frame(8'h55, 1'b0, 11);
    check("t6_glitch_q", {8'h00, q}, 16'h0055);
    check("t6_glitch_intr", {15'd0, intr}, 16'd1);

    // 6b: reset in the middle of a frame
    send_frame(8'h77, 1'b0, 4);
    reset_n = 1'b0;
    @(negedge clock);
    check("t6_rst_q", {8'h00, q}, 16'h0000);
    check("t6_rst_empty", {15'd0, empty}, 16'd1);
    check("t6_rst_intr", {15'd0, intr}, 16'd0);
    check("t6_rst_ovf", {15'd0, ovf}, 16'd0);
    check("t6_rst_perr", {15'd0, perr}, 16'd0);
    reset_n = 1'b1;
    idle(5);
    send_frame(8'h3A, 1'b0, 11);
    pop_check("t6_after_rst", 8'h3A);
    idle(1);
    check("t6_final_empty", {15'd0, empty}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
